// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: opcode/handshake inputs and control strobes between the control FSM and its datapath.
interface mips_mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode, funct;
    logic             imem_ready, dmem_ready, alu_nonzero;
    logic             imem_req, ir_we, pc_we, pc_src, alu_out_we, dmem_re, dmem_we;
    logic             reg_we, reg_dst, mem_to_reg, illegal, bus_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;
    modport master (
        input  opcode, funct, imem_ready, dmem_ready, alu_nonzero,
        output imem_req, ir_we, pc_we, pc_src, alu_out_we, dmem_re, dmem_we,
        output reg_we, reg_dst, mem_to_reg, illegal, bus_err, state, instr_count
    );
    modport slave (
        output opcode, funct, imem_ready, dmem_ready, alu_nonzero,
        input  imem_req, ir_we, pc_we, pc_src, alu_out_we, dmem_re, dmem_we,
        input  reg_we, reg_dst, mem_to_reg, illegal, bus_err, state, instr_count
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with bus timeout and retire counter.
// Strobes decode combinationally from the registered state and are held low while rst is high.
module mips_mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst,
    mips_mc_ctrl_if.master bus
);
    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_e;
    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q;
    logic is_r, r_ok, is_imm, is_ld, is_st, is_br, is_j, legal, run;
    logic in_f, in_d, in_e, in_m, in_w, rdy, waiting, tmo, retire;
    assign is_r   = bus.opcode == 6'b000000;
    assign r_ok   = is_r && bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                              6'b100110, 6'b101010, 6'b000000, 6'b000010};
    assign is_imm = bus.opcode inside {6'b001000, 6'b001100};
    assign is_ld  = bus.opcode == 6'b100011;
    assign is_st  = bus.opcode == 6'b101011;
    assign is_br  = bus.opcode inside {6'b000100, 6'b000101};
    assign is_j   = bus.opcode == 6'b000010;
    assign legal  = r_ok || is_imm || is_ld || is_st || is_br || is_j;
    assign in_f = state_q == FETCH;
    assign in_d = state_q == DECODE;
    assign in_e = state_q == EXEC;
    assign in_m = state_q == MEM;
    assign in_w = state_q == WB;
    assign rdy     = in_f ? bus.imem_ready : bus.dmem_ready;
    assign waiting = (in_f || in_m) && !rdy;
    // wait_q holds the waits before this cycle, so the MEM_TIMEOUT-th wait fires here
    assign tmo     = MEM_TIMEOUT != 0 && waiting && wait_q == WW'(MEM_TIMEOUT - 1);
    assign retire  = (in_e && (is_br || is_j)) || (in_m && bus.dmem_ready && is_st) || in_w;
    assign wait_d  = waiting && !tmo ? wait_q + 1'b1 : '0;
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = bus.imem_ready ? DECODE : FETCH;
            DECODE: state_d = legal ? EXEC : FETCH;
            EXEC:   state_d = (is_ld || is_st) ? MEM : (is_br || is_j) ? FETCH : WB;
            MEM:    state_d = bus.dmem_ready ? (is_ld ? WB : FETCH) : tmo ? FETCH : MEM;
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_q + CNT_W'(retire);
        end
    end
    assign run            = !rst;
    assign bus.imem_req   = run && in_f;
    assign bus.ir_we      = run && in_f && bus.imem_ready;
    assign bus.pc_we      = run && ((in_f && bus.imem_ready) || (in_e && (is_j || (is_br && bus.alu_nonzero))));
    assign bus.pc_src     = run && in_e && (is_br || is_j);
    assign bus.alu_out_we = run && in_e;
    assign bus.dmem_re    = run && in_m && is_ld;
    assign bus.dmem_we    = run && in_m && is_st;
    assign bus.reg_we     = run && in_w;
    assign bus.reg_dst    = run && in_w && is_r;
    assign bus.mem_to_reg = run && in_w && is_ld;
    assign bus.illegal    = run && in_d && !legal;
    assign bus.bus_err    = run && tmo;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: randomized instruction stream checked against a per-instruction cycle schedule.
module tb_mips_mc_ctrl;
    localparam int TMO = 4;
    localparam logic [11:0] S_IMR = 12'h800, S_IR = 12'h400, S_PC = 12'h200, S_SRC = 12'h100,
                            S_ALU = 12'h080, S_DRE = 12'h040, S_DWE = 12'h020, S_RW = 12'h010,
                            S_RD = 12'h008, S_MR = 12'h004, S_ILL = 12'h002, S_BE = 12'h001;
    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    logic clk = 1'b0, rst = 1'b1;
    int n_chk = 0, n_err = 0, cnt = 0;
    logic [5:0] ops  [7] = '{OP_R, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
    logic [5:0] r_fn [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010, 6'b000000, 6'b000010};
    logic [11:0] obs;
    mips_mc_ctrl_if #(.CNT_W(4)) bus ();
    mips_mc_ctrl #(.CNT_W(4), .MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign obs = {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_out_we, bus.dmem_re,
                  bus.dmem_we, bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.illegal, bus.bus_err};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_R) begin
            for (int i = 0; i < 8; i++) if (r_fn[i] == fn) return 1'b1;
            return 1'b0;
        end
        for (int i = 1; i < 7; i++) if (ops[i] == op) return 1'b1;
        return op == OP_J;
    endfunction
    task automatic cyc(input logic [2:0] st, input logic [11:0] s, input logic ir, input logic dr);
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        #1;
        check("state", 32'(bus.state), 32'(st));
        check("strobes", 32'(obs), 32'(s));
        @(negedge clk);
    endtask
    // One instruction: wf fetch waits, wm memory waits (>= TMO means the access times out)
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm, input logic nz);
        logic [11:0] ms;
        bus.opcode = op;
        bus.funct = fn;
        bus.alu_nonzero = nz;
        for (int k = 0; k < wf; k++) cyc(3'd0, S_IMR | ((k % TMO == TMO - 1) ? S_BE : 12'h0), 1'b0, 1'b0);
        cyc(3'd0, S_IMR | S_IR | S_PC, 1'b1, 1'b0);
        if (!legal(op, fn)) cyc(3'd1, S_ILL, 1'b0, 1'b0);
        else begin
            cyc(3'd1, 12'h0, 1'b0, 1'b0);
            if (op == OP_BEQ || op == OP_BNE) begin
                cyc(3'd2, S_ALU | S_SRC | (nz ? S_PC : 12'h0), 1'b0, 1'b0);
                cnt++;
            end else if (op == OP_J) begin
                cyc(3'd2, S_ALU | S_SRC | S_PC, 1'b0, 1'b0);
                cnt++;
            end else if (op == OP_LW || op == OP_SW) begin
                ms = op == OP_LW ? S_DRE : S_DWE;
                cyc(3'd2, S_ALU, 1'b0, 1'b0);
                for (int k = 0; k < wm && k < TMO; k++) cyc(3'd3, ms | (k == TMO - 1 ? S_BE : 12'h0), 1'b0, 1'b0);
                if (wm < TMO) begin
                    cyc(3'd3, ms, 1'b0, 1'b1);
                    if (op == OP_LW) cyc(3'd4, S_RW | S_MR, 1'b0, 1'b0);
                    cnt++;
                end
            end else begin
                cyc(3'd2, S_ALU, 1'b0, 1'b0);
                cyc(3'd4, S_RW | (op == OP_R ? S_RD : 12'h0), 1'b0, 1'b0);
                cnt++;
            end
        end
        check("count", 32'(bus.instr_count), 32'(cnt[3:0]));
    endtask
    initial begin
        logic [5:0] op, fn;
        int k;
        bus.opcode = '0; bus.funct = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.alu_nonzero = 1'b0;
        @(negedge clk);
        #1;
        check("rst_strobes", 32'(obs), 32'h0);
        check("rst_state", 32'(bus.state), 32'h0);
        check("rst_count", 32'(bus.instr_count), 32'h0);
        rst = 1'b0;
        #1;
        check("first_req", 32'(bus.imem_req), 32'h1);
        @(negedge clk);
        run_instr(OP_R, 6'b100000, 0, 0, 1'b0);
        run_instr(OP_LW, 6'b0, 0, 3, 1'b0);
        run_instr(OP_BEQ, 6'b0, 0, 0, 1'b1);
        run_instr(OP_BNE, 6'b0, 0, 0, 1'b0);
        run_instr(6'b111111, 6'b0, 0, 0, 1'b0);
        run_instr(OP_R, 6'b001000, 0, 0, 1'b0);
        run_instr(OP_SW, 6'b0, 0, 9, 1'b0);
        run_instr(OP_J, 6'b0, 9, 0, 1'b0);
        // reset while LW waits in MEM
        bus.opcode = OP_LW;
        cyc(3'd0, S_IMR | S_IR | S_PC, 1'b1, 1'b0);
        cyc(3'd1, 12'h0, 1'b0, 1'b0);
        cyc(3'd2, S_ALU, 1'b0, 1'b0);
        bus.dmem_ready = 1'b0;
        #1;
        check("mem_dre", 32'(bus.dmem_re), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_strobes", 32'(obs), 32'h0);
        check("midrst_state", 32'(bus.state), 32'h0);
        check("midrst_count", 32'(bus.instr_count), 32'h0);
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k < 7) begin
                op = ops[k];
                fn = r_fn[$urandom_range(0, 7)];
            end else if (k == 7) begin
                op = OP_J;
                fn = 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn, $urandom_range(0, 9), $urandom_range(0, 5), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
